// File: rtl/uart_rx_ext.sv
// UART receiver: 5-9 data bits, optional even/odd parity, 1 or 2 stop bits.
// It takes a three-sample majority vote around mid-bit and detects false
// starts, parity errors, framing errors and breaks. Frames are buffered in a
// small FIFO with a valid/ready read side and a sticky overrun flag.
module uart_rx_ext #(
  parameter int MAX_DATA_BITS = 9,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_W         = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          uart_rxd,
  input  logic                          uart_rx_en,
  input  logic [CNT_W-1:0]              CYCLES_PER_BIT,
  input  logic [3:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [MAX_DATA_BITS-1:0]      rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_break,
  output logic                          rx_overrun,
  input  logic                          clear_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int ENT_W = MAX_DATA_BITS + 3;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
  } state_t;

  state_t                     state, state_nxt;
  logic                       sync1, sync2;
  logic [CNT_W-1:0]           cnt, per_p, half;
  logic                       at_s0, at_s1, at_s2, bit_end;
  logic                       samp0, samp1, maj;
  logic [3:0]                 lat_nbits, bitcnt;
  logic [1:0]                 lat_par;
  logic                       lat_stop2;
  logic [MAX_DATA_BITS-1:0]   shreg;
  logic                       par_bit, stop1_low;
  logic                       par_en, par_x, perr, ferr, first_low, brk, final_stop;
  logic                       push;

  logic [ENT_W-1:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wptr, rptr;
  logic                       full, pop, wr_en, ovr_set;
  logic [ENT_W-1:0]           head;

  // Bit timing: period clamped to >= 4, samples at H-1, H, H+1.
  assign per_p   = (CYCLES_PER_BIT < CNT_W'(4)) ? CNT_W'(4) : CYCLES_PER_BIT;
  assign half    = per_p >> 1;
  assign at_s0   = (cnt == half - CNT_W'(1));
  assign at_s1   = (cnt == half);
  assign at_s2   = (cnt == half + CNT_W'(1));
  assign bit_end = (cnt == per_p - CNT_W'(1));
  assign maj     = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);

  // Frame status, evaluated at the final stop-bit sample.
  assign par_en     = (lat_par == 2'b01) || (lat_par == 2'b10);
  assign par_x      = (^shreg) ^ par_bit;
  assign perr       = par_en & ((lat_par == 2'b01) ? par_x : ~par_x);
  assign final_stop = lat_stop2 ? (bitcnt == 4'd1) : 1'b1;
  assign ferr       = stop1_low | ~maj;
  assign first_low  = lat_stop2 ? stop1_low : ~maj;
  assign brk        = (shreg == '0) & (~par_en | ~par_bit) & first_low;

  // Two-flop synchroniser; idles high while the receiver is disabled.
  always_ff @(posedge clk) begin
    if (!resetn || !uart_rx_en) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= uart_rxd;
      sync2 <= sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM next-state and push decision.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      S_IDLE:    if (!sync2) state_nxt = S_START;
      S_START: begin
        if (at_s2 && maj) state_nxt = S_IDLE;
        else if (bit_end) state_nxt = S_DATA;
      end
      S_DATA:    if (bit_end && (bitcnt == lat_nbits - 4'd1))
                   state_nxt = par_en ? S_PARITY : S_STOP;
      S_PARITY:  if (bit_end) state_nxt = S_STOP;
      S_STOP: begin
        if (at_s2 && final_stop) begin
          push      = 1'b1;
          state_nxt = brk ? S_BRKWAIT : S_IDLE;
        end
      end
      S_BRKWAIT: if (sync2) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    if (!uart_rx_en) begin
      state_nxt = S_IDLE;
      push      = 1'b0;
    end
  end

  // Receive datapath: bit counter, samples, shift register, latched config.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt       <= '0;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
      bitcnt    <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      stop1_low <= 1'b0;
      lat_nbits <= 4'd8;
      lat_par   <= 2'b00;
      lat_stop2 <= 1'b0;
    end else begin
      if (state == S_IDLE || bit_end) cnt <= '0;
      else                            cnt <= cnt + 1'b1;
      if (at_s0) samp0 <= sync2;
      if (at_s1) samp1 <= sync2;
      case (state)
        S_IDLE: begin
          if (!sync2) begin
            lat_nbits <= (cfg_data_bits < 4'd5) ? 4'd5 :
                         (cfg_data_bits > 4'(MAX_DATA_BITS)) ? 4'(MAX_DATA_BITS) :
                         cfg_data_bits;
            lat_par   <= cfg_parity;
            lat_stop2 <= cfg_stop2;
            shreg     <= '0;
            bitcnt    <= '0;
            par_bit   <= 1'b0;
            stop1_low <= 1'b0;
          end
        end
        S_DATA: begin
          if (at_s2) shreg[bitcnt] <= maj;
          if (bit_end) bitcnt <= (bitcnt == lat_nbits - 4'd1) ? 4'd0 : bitcnt + 4'd1;
        end
        S_PARITY: if (at_s2) par_bit <= maj;
        S_STOP: begin
          if (at_s2 && bitcnt == 4'd0) stop1_low <= ~maj;
          if (bit_end) bitcnt <= bitcnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // FIFO control: a push while full succeeds only if a pop frees the slot.
  assign rx_valid = (fifo_level != '0);
  assign full     = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign pop      = rx_valid & rx_ready;
  assign wr_en    = push & (~full | pop);
  assign ovr_set  = push & full & ~pop;

  // FIFO pointers, level and sticky overrun (set beats clear).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      rx_overrun <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (ovr_set)            rx_overrun <= 1'b1;
      else if (clear_overrun) rx_overrun <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset because outputs are gated by rx_valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= {brk, ferr, perr, shreg};
  end

  assign head          = mem[rptr];
  assign rx_data       = rx_valid ? head[MAX_DATA_BITS-1:0] : '0;
  assign rx_parity_err = rx_valid & head[MAX_DATA_BITS];
  assign rx_frame_err  = rx_valid & head[MAX_DATA_BITS+1];
  assign rx_break      = rx_valid & head[MAX_DATA_BITS+2];

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scoreboard bench for uart_rx_ext: stimulus queues expected entries,
// a negedge monitor compares every popped FIFO head.
module tb_uart_rx_ext;

  localparam int P = 16;

  logic        clk, resetn, uart_rxd, uart_rx_en;
  logic [15:0] CYCLES_PER_BIT;
  logic [3:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        rx_valid, rx_ready;
  logic [8:0]  rx_data;
  logic        rx_parity_err, rx_frame_err, rx_break, rx_overrun, clear_overrun;
  logic [2:0]  fifo_level;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q [$];

  uart_rx_ext #(.MAX_DATA_BITS(9), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
    .CYCLES_PER_BIT(CYCLES_PER_BIT), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
    .rx_frame_err(rx_frame_err), .rx_break(rx_break), .rx_overrun(rx_overrun),
    .clear_overrun(clear_overrun), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mk(input logic b, input logic f, input logic p,
                                     input logic [8:0] d);
    return {b, f, p, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each entry the consumer accepts against the scoreboard.
  always @(negedge clk) begin
    logic [11:0] got, e;
    if (resetn && rx_valid && rx_ready) begin
      got = {rx_break, rx_frame_err, rx_parity_err, rx_data};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_entry got=%h exp=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL entry got=%h exp=%h", got, e);
        end
      end
    end
  end

  // All stimulus runs in the posedge+1 phase.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b, input int glitch_at);
    for (int c = 0; c < P; c++) begin
      uart_rxd = (c == glitch_at) ? ~b : b;
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [8:0] d, input int nb, input int par,
                            input bit par_flip, input bit st1, input bit st2,
                            input bit two, input int glitch_bit);
    logic pb;
    drive_bit(1'b0, -1);
    pb = 1'b0;
    for (int i = 0; i < nb; i++) begin
      drive_bit(d[i], (i == glitch_bit) ? 9 : -1);
      pb = pb ^ d[i];
    end
    if (par != 0) begin
      if (par == 2) pb = ~pb;
      drive_bit(pb ^ par_flip, -1);
    end
    drive_bit(st1, -1);
    if (two) drive_bit(st2, -1);
    uart_rxd = 1'b1;
  endtask

  task automatic cfg(input logic [3:0] nb, input logic [1:0] par, input logic s2);
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop2     = s2;
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; uart_rxd = 1'b1; uart_rx_en = 1'b1; rx_ready = 1'b0;
    clear_overrun = 1'b0; CYCLES_PER_BIT = 16'(P);
    cfg(4'd8, 2'b00, 1'b0);
    tick(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_errs", {rx_break, rx_frame_err, rx_parity_err}, 0);
    chk("rst_overrun", rx_overrun, 0);
    chk("rst_level", fifo_level, 0);
    resetn = 1'b1;
    tick(4);

    // 8N1 0xA5: push during the cycle after edge 156, visible after edge 157.
    exp_q.push_back(mk(0, 0, 0, 9'h0A5));
    fork
      send_frame(9'h0A5, 8, 0, 0, 1, 1, 0, -1);
      begin
        tick(156);
        chk("valid_before_push", rx_valid, 0);
        tick(1);
        chk("valid_after_push", rx_valid, 1);
        chk("level_one", fifo_level, 1);
      end
    join
    tick(8);
    rx_ready = 1'b1;
    tick(4);
    chk("level_drained", fifo_level, 0);

    // 7 data bits: even parity with wrong bit, then odd parity with correct bit.
    cfg(4'd7, 2'b01, 1'b0);
    exp_q.push_back(mk(0, 0, 1, 9'h035));
    send_frame(9'h035, 7, 1, 1, 1, 1, 0, -1);
    tick(32);
    cfg(4'd7, 2'b10, 1'b0);
    exp_q.push_back(mk(0, 0, 0, 9'h035));
    send_frame(9'h035, 7, 2, 0, 1, 1, 0, -1);
    tick(32);

    // 9 data bits, two stop bits, second stop low.
    cfg(4'd9, 2'b00, 1'b1);
    exp_q.push_back(mk(0, 1, 0, 9'h1FF));
    send_frame(9'h1FF, 9, 0, 0, 1, 0, 1, -1);
    tick(48);

    // Break: line low for 20 bit times yields exactly one entry.
    rx_ready = 1'b0;
    exp_q.push_back(mk(1, 1, 0, 9'h000));
    uart_rxd = 1'b0;
    tick(20 * P);
    uart_rxd = 1'b1;
    tick(48);
    chk("break_single", fifo_level, 1);
    rx_ready = 1'b1;
    tick(8);

    // Idle glitch, then a single-cycle glitch mid data bit.
    cfg(4'd8, 2'b00, 1'b0);
    rx_ready = 1'b0;
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(64);
    chk("false_start_level", fifo_level, 0);
    exp_q.push_back(mk(0, 0, 0, 9'h096));
    send_frame(9'h096, 8, 0, 0, 1, 1, 0, 3);
    tick(32);
    chk("glitch_level", fifo_level, 1);
    rx_ready = 1'b1;
    tick(8);

    // Overrun: five frames into a four-deep FIFO.
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(mk(0, 0, 0, 9'(i * 17)));
      send_frame(9'(i * 17), 8, 0, 0, 1, 1, 0, -1);
      tick(8);
    end
    chk("full_level", fifo_level, 4);
    chk("overrun_set", rx_overrun, 1);
    exp_q.push_back(mk(0, 0, 0, 9'h066));
    fork
      send_frame(9'h066, 8, 0, 0, 1, 1, 0, -1);
      begin
        tick(156);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        chk("push_pop_full_level", fifo_level, 4);
      end
    join
    tick(8);
    clear_overrun = 1'b1;
    tick(1);
    clear_overrun = 1'b0;
    chk("overrun_cleared", rx_overrun, 0);
    fork
      send_frame(9'h077, 8, 0, 0, 1, 1, 0, -1);
      begin
        tick(156);
        clear_overrun = 1'b1;
        tick(1);
        clear_overrun = 1'b0;
        chk("overrun_set_wins", rx_overrun, 1);
        chk("drop_level", fifo_level, 4);
      end
    join
    tick(8);
    rx_ready = 1'b1;
    tick(2);
    rx_ready = 1'b0;
    chk("two_popped_level", fifo_level, 2);

    // Reset mid-DATA with two entries queued and overrun set.
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b1, -1);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    exp_q.delete();
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_overrun", rx_overrun, 0);
    chk("midrst_data", rx_data, 0);
    uart_rxd = 1'b1;
    tick(32);
    chk("midrst_no_push", fifo_level, 0);
    exp_q.push_back(mk(0, 0, 0, 9'h03C));
    send_frame(9'h03C, 8, 0, 0, 1, 1, 0, -1);
    tick(32);
    chk("post_rst_frame", fifo_level, 1);
    rx_ready = 1'b1;
    tick(8);

    // Receive disable mid-frame aborts without a push.
    rx_ready = 1'b0;
    drive_bit(1'b0, -1);
    drive_bit(1'b0, -1);
    uart_rx_en = 1'b0;
    drive_bit(1'b0, -1);
    drive_bit(1'b0, -1);
    uart_rxd = 1'b1;
    tick(4);
    uart_rx_en = 1'b1;
    tick(16 * P);
    chk("disable_no_push", fifo_level, 0);
    exp_q.push_back(mk(0, 0, 0, 9'h05A));
    send_frame(9'h05A, 8, 0, 0, 1, 1, 0, -1);
    tick(32);
    chk("post_disable_frame", fifo_level, 1);
    rx_ready = 1'b1;
    tick(8);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
